n2tl_gntack_gen: RTL
====================

// Module: n2tl_gntack_gen
// PURPOSE
//  TileLink E-channel GrantAck generator; direct downstream consumer of the N2TL acquire state machine.
//  On gntack_gen_en: captures e_sink, builds one 64-bit OmniXtend E-channel GrantAck flit, hands it to OXmgr TX over valid/ready.
//  Returns a one-cycle gntack_gen_done pulse so the acquire FSM can leave its GntAck state.
//  Also keeps a sent-GrantAck counter and a sticky TX-stall timeout flag.
// PARAMETERS
//  SINK_W     26      width of e_sink / sink field in flit
//  FLIT_W     64      width of tx_flit
//  CHAN_E     3'd5    OmniXtend channel code for E
//  TMO_CYC    1024    tx_ready-low cycles in SEND before err_tmo sets (>=2)
//  CNT_W      16      width of gntack_cnt
// PORTS
//  clk            in   1       clock
//  reset          in   1       async, active-high reset
//  gntack_gen_en  in   1       level from acquire FSM: "send GrantAck"
//  e_sink         in   SINK_W  sink ID for GrantAck; valid while gntack_gen_en=1
//  tx_ready       in   1       OXmgr TX can accept a flit
//  err_clr        in   1       clears err_tmo (pulse)
//  gntack_gen_done out 1       1-cycle pulse: flit accepted by TX
//  tx_valid       out  1       tx_flit valid
//  tx_flit        out  FLIT_W  GrantAck flit
//  gntack_cnt     out  CNT_W   count of accepted GrantAcks, wraps
//  err_tmo        out  1       sticky: TX stalled TMO_CYC cycles
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sink_q=0, stall counter=0; async assert, deassert sync to clk.
//  Reset mid-op: in-flight flit dropped; tx_valid falls asynchronously; no done pulse.
//  One-hot FSM IDLE, LOAD, SEND, DONE, RELEASE:
//   IDLE: gntack_gen_en=1 -> LOAD.
//   LOAD: sink_q<=e_sink (e_sink is registered upstream, so it is sampled one cycle late) -> SEND.
//   SEND: tx_valid=1, tx_flit stable. tx_valid&tx_ready at edge -> DONE.
//   DONE: gntack_gen_done=1 for this cycle only; gntack_cnt+1 mod 2^CNT_W -> RELEASE.
//   RELEASE: wait gntack_gen_en=0 -> IDLE. The en level that caused this send never retriggers.
//  Latency: en sampled high at edge N -> tx_valid at N+2 -> done pulse the cycle after the accept edge.
//  Minimum en-to-done: 3 cycles.
//  tx_flit format: [63]=0, [62:60]=CHAN_E, [59:57]=3'b000 (GrantAck), [56:SINK_W]=0, [SINK_W-1:0]=sink_q.
//  tx_flit is 0 whenever tx_valid=0.
//  Valid/ready: tx_valid never drops and tx_flit never changes in SEND until accepted; tx_ready ignored outside SEND.
//  Stall counter: counts SEND cycles with tx_ready=0; cleared on leaving SEND; saturates at TMO_CYC.
//   Reaching TMO_CYC sets err_tmo. FSM keeps waiting in SEND; no flit is dropped.
//  err_clr=1 clears err_tmo. If clear and set happen on the same edge, set wins.
//  gntack_gen_en dropping while in LOAD/SEND: flit still sent, done still pulsed (protocol violation tolerated).
// TESTING
//  1 Basic: e_sink=26'h155, en=1 at cyc0, tx_ready=1
//    -> tx_valid cyc2, tx_flit=64'h5000_0000_0000_0155, done pulse cyc3, gntack_cnt=1, busy=0 by cyc5.
//  2 Backpressure: tx_ready=0 for 10 cycles in SEND
//    -> tx_valid/tx_flit held, no done; single done 1 cycle after ready=1; err_tmo=0.
//  3 Timeout (TMO_CYC=8): tx_ready=0 for 8 cycles -> err_tmo=1, still SEND;
//    ready=1 -> done; err_clr -> err_tmo=0; err_clr on the set edge -> stays 1.
//  4 Back-to-back: en held high 2 extra cycles after done, then pulsed again with e_sink=26'h3FF_FFFF
//    -> exactly 2 flits, second sink field all ones, gntack_cnt=2.
//  5 Reset mid-SEND: reset=1 while tx_valid=1 -> tx_valid=0 same cycle, no done, cnt unchanged
//    -> after release, new en sends normally.
//  6 Wrap: preload via CNT_W=4 build, 16 GrantAcks -> gntack_cnt=0.

Source files
------------

// File: rtl/n2tl_gntack_gen.sv
// n2tl_gntack_gen: builds one E-channel GrantAck flit per acquire request and hands it to TX over valid/ready.
module n2tl_gntack_gen #(
  parameter int SINK_W = 26,
  parameter int FLIT_W = 64,
  parameter logic [2:0] CHAN_E = 3'd5,
  parameter int TMO_CYC = 1024,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gntack_gen_en,
  input  logic [SINK_W-1:0] e_sink,
  input  logic              tx_ready,
  input  logic              err_clr,
  output logic              gntack_gen_done,
  output logic              tx_valid,
  output logic [FLIT_W-1:0] tx_flit,
  output logic [CNT_W-1:0]  gntack_cnt,
  output logic              err_tmo,
  output logic              busy
);
  localparam int STW = $clog2(TMO_CYC + 1);
  localparam logic [STW-1:0] TMO_MAX = STW'(TMO_CYC);
  localparam int I_IDLE = 0, I_LOAD = 1, I_SEND = 2, I_DONE = 3, I_REL = 4;
  localparam logic [4:0] S_IDLE = 5'b00001, S_LOAD = 5'b00010, S_SEND = 5'b00100,
                         S_DONE = 5'b01000, S_REL = 5'b10000;
  logic [4:0]        r_state, w_next;
  logic [SINK_W-1:0] r_sink;
  logic [CNT_W-1:0]  r_cnt;
  logic [STW-1:0]    r_stall;
  logic              r_err;
  logic              w_set;
  logic [FLIT_W-1:0] w_flit;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  // RELEASE holds until en drops so the level that caused a send can never retrigger it
  always_comb begin
    w_next = r_state[I_IDLE] ? (gntack_gen_en ? S_LOAD : S_IDLE) :
             r_state[I_LOAD] ? S_SEND :
             r_state[I_SEND] ? (tx_ready ? S_DONE : S_SEND) :
             r_state[I_DONE] ? S_REL :
             r_state[I_REL]  ? (gntack_gen_en ? S_REL : S_IDLE) : S_IDLE;
  end
  assign w_set  = r_state[I_SEND] & ~tx_ready & (r_stall == TMO_MAX - STW'(1));
  assign w_flit = {1'b0, CHAN_E, 3'b000, {(FLIT_W-7-SINK_W){1'b0}}, r_sink};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sink  <= '0;
      r_cnt   <= '0;
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state[I_LOAD]) r_sink <= e_sink;
      if (r_state[I_DONE]) r_cnt <= r_cnt + CNT_W'(1);
      r_stall <= !r_state[I_SEND] ? '0 :
                 (!tx_ready && r_stall != TMO_MAX) ? r_stall + STW'(1) : r_stall;
      r_err   <= w_set | (r_err & ~err_clr);
    end
  always_comb begin
    tx_valid        = r_state[I_SEND];
    tx_flit         = r_state[I_SEND] ? w_flit : '0;
    gntack_gen_done = r_state[I_DONE];
    busy            = ~r_state[I_IDLE];
    gntack_cnt      = r_cnt;
    err_tmo         = r_err;
  end
endmodule
